// File: rtl/qr_scan_pkg.sv
// qr_scan_pkg: shared types, widths and ratio constants for the
// QR finder line scanner (optional counters: FINDER_MATCH_COUNT_EN).
package qr_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROWS,
    COLS,
    DRAIN
  } scan_state_t;

  localparam int RUN_W   = 9;
  localparam int TOTAL_W = 12;
  localparam int ADDR_W  = 20;
  localparam int COORD_W = 9;
  localparam int EVAL_W  = 14;
  localparam int MAX_DIM = 480;

  localparam logic [EVAL_W-1:0] RATIO_UNIT = 14'd7;
  localparam logic [EVAL_W-1:0] RATIO_CORE = 14'd3;
  localparam logic [EVAL_W-1:0] MIN_TOTAL  = 14'd7;
  localparam int OUTER_TOL_SHIFT = 1;
  localparam int CORE_TOL_SHIFT  = 0;

  typedef struct packed {
    logic [RUN_W-1:0] len;
    logic             color;
  } run_t;

  typedef struct packed {
    logic               valid;
    logic               phase;
    logic               first;
    logic               last;
    logic [COORD_W-1:0] coord;
  } scan_tag_t;

  function automatic logic [EVAL_W-1:0] abs_diff(
    input logic [EVAL_W-1:0] a,
    input logic [EVAL_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Outer runs: |7r - T| <= T/2
  function automatic logic outer_ok(
    input logic [RUN_W-1:0]  r,
    input logic [EVAL_W-1:0] t
  );
    logic [EVAL_W-1:0] s;
    s = RATIO_UNIT * EVAL_W'(r);
    return abs_diff(s, t) <= (t >> OUTER_TOL_SHIFT);
  endfunction

  // Core run: |7r - 3T| <= T
  function automatic logic core_ok(
    input logic [RUN_W-1:0]  r,
    input logic [EVAL_W-1:0] t
  );
    logic [EVAL_W-1:0] s;
    logic [EVAL_W-1:0] u;
    s = RATIO_UNIT * EVAL_W'(r);
    u = RATIO_CORE * t;
    return abs_diff(s, u) <= (t >> CORE_TOL_SHIFT);
  endfunction

endpackage

// File: rtl/run_ratio_tracker.sv
// run_ratio_tracker: per-pixel run-length history along one line,
// flags a 1:1:3:1:1 B/W/B/W/B match and its centre coordinate.
module run_ratio_tracker
  import qr_scan_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  input  logic               pixel_in,
  input  logic [COORD_W-1:0] coord_in,
  input  logic               first_in,
  input  logic               last_in,
  output logic               match_out,
  output logic [COORD_W-1:0] center_out
);

  run_t [4:0]         hist_q, hist_d;
  logic [2:0]         cnt_q, cnt_d;
  run_t               cur_q, cur_d;
  logic               match_q, match_d;
  logic [COORD_W-1:0] center_q, center_d;

  run_t [4:0]         base_h, eval_h;
  logic [2:0]         base_cnt, eval_cnt;
  run_t               base_cur, fresh;
  logic               change, close_black, end_black;
  logic               colors_ok, ratio_ok;
  logic [TOTAL_W-1:0] tot;
  logic [EVAL_W-1:0]  t14;
  logic [COORD_W-1:0] end_c;

  function automatic logic [2:0] bump(input logic [2:0] c);
    return (c == 3'd5) ? c : c + 3'd1;
  endfunction

  // Run extension / closure and ratio evaluation for the incoming pixel
  always_comb begin
    base_h   = hist_q;
    base_cnt = cnt_q;
    base_cur = cur_q;
    if (first_in) begin
      base_h   = '0;
      base_cnt = '0;
      base_cur = '0;
    end
    change      = (base_cur.len != '0) && (base_cur.color != pixel_in);
    fresh.len   = RUN_W'(1);
    fresh.color = pixel_in;
    hist_d = base_h;
    cnt_d  = base_cnt;
    cur_d  = base_cur;
    if (change) begin
      hist_d = {base_h[3:0], base_cur};
      cnt_d  = bump(base_cnt);
    end
    if (change || base_cur.len == '0) begin
      cur_d = fresh;
    end else if (base_cur.len != '1) begin
      cur_d.len = base_cur.len + RUN_W'(1);
    end
    // A black run closes on a black->white step or at a black line end
    close_black = change && pixel_in;
    end_black   = last_in && !pixel_in;
    eval_h   = hist_d;
    eval_cnt = cnt_d;
    if (end_black) begin
      eval_h   = {hist_d[3:0], cur_d};
      eval_cnt = bump(cnt_d);
    end
    colors_ok = {eval_h[4].color, eval_h[3].color, eval_h[2].color,
                 eval_h[1].color, eval_h[0].color} == 5'b01010;
    tot = TOTAL_W'(eval_h[0].len) + TOTAL_W'(eval_h[1].len)
        + TOTAL_W'(eval_h[2].len) + TOTAL_W'(eval_h[3].len)
        + TOTAL_W'(eval_h[4].len);
    t14 = EVAL_W'(tot);
    ratio_ok = (t14 >= MIN_TOTAL)
             && outer_ok(eval_h[0].len, t14)
             && outer_ok(eval_h[1].len, t14)
             && core_ok(eval_h[2].len, t14)
             && outer_ok(eval_h[3].len, t14)
             && outer_ok(eval_h[4].len, t14);
    match_d = valid_in && (close_black || end_black)
            && (eval_cnt == 3'd5) && colors_ok && ratio_ok;
    // Exclusive end of the last black run, walked back to the core start
    end_c = coord_in + COORD_W'(end_black);
    center_d = end_c - COORD_W'(eval_h[0].len)
             - COORD_W'(eval_h[1].len) - COORD_W'(eval_h[2].len)
             + COORD_W'(eval_h[2].len >> 1);
  end

  // History registers advance only on valid pixels
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_q   <= '0;
      cnt_q    <= '0;
      cur_q    <= '0;
      match_q  <= 1'b0;
      center_q <= '0;
    end else begin
      if (valid_in) begin
        hist_q <= hist_d;
        cnt_q  <= cnt_d;
        cur_q  <= cur_d;
      end
      match_q  <= match_d;
      center_q <= center_d;
    end
  end

  assign match_out  = match_q;
  assign center_out = center_q;

endmodule

// File: rtl/finder_line_scanner.sv
// finder_line_scanner: row then column BRAM scan for finder patterns.
// Define FINDER_MATCH_COUNT_EN to add per-phase match counters.
module finder_line_scanner
  import qr_scan_pkg::*;
#(
  parameter int HEIGHT       = 480,
  parameter int WIDTH        = 480,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               pixel_in,
  output logic [ADDR_W-1:0]  address_out,
  output logic [MAX_DIM-1:0] horz_patterns,
  output logic [MAX_DIM-1:0] vert_patterns,
  output logic               busy_out,
  output logic               done_out
`ifdef FINDER_MATCH_COUNT_EN
  ,
  output logic [15:0]        horz_match_count,
  output logic [15:0]        vert_match_count
`endif
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  STEP_Y = ADDR_W'(WIDTH);
  localparam int DRAIN_W = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY);

  scan_state_t        state_q, state_d;
  logic [COORD_W-1:0] along_q, along_d;
  logic [COORD_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic [MAX_DIM-1:0] horz_q, horz_d;
  logic [MAX_DIM-1:0] vert_q, vert_d;
  logic               mphase_q, mphase_d;

  scan_tag_t [READ_LATENCY-1:0] tag_q, tag_d;
  scan_tag_t          cur_tag, tag_out;
  logic               match;
  logic [COORD_W-1:0] center;

`ifdef FINDER_MATCH_COUNT_EN
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
`endif

  assign tag_out = tag_q[READ_LATENCY-1];

  // Tag for the address currently on the bus, delayed to meet its data
  always_comb begin
    cur_tag.valid = (state_q == ROWS) || (state_q == COLS);
    cur_tag.phase = (state_q == COLS);
    cur_tag.first = (along_q == '0);
    cur_tag.last  = (state_q == COLS) ? (along_q == LAST_Y)
                                      : (along_q == LAST_X);
    cur_tag.coord = along_q;
    tag_d[0] = cur_tag;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    mphase_d = tag_out.phase;
  end

  run_ratio_tracker u_tracker (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (tag_out.valid),
    .pixel_in   (pixel_in),
    .coord_in   (tag_out.coord),
    .first_in   (tag_out.first),
    .last_in    (tag_out.last),
    .match_out  (match),
    .center_out (center)
  );

  // Scan sequencer and candidate vector update
  always_comb begin
    state_d = state_q;
    along_d = along_q;
    line_d  = line_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    horz_d  = horz_q;
    vert_d  = vert_q;
`ifdef FINDER_MATCH_COUNT_EN
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
`endif
    if (match && center < COORD_W'(MAX_DIM)) begin
      if (mphase_q) vert_d[center] = 1'b1;
      else          horz_d[center] = 1'b1;
    end
`ifdef FINDER_MATCH_COUNT_EN
    if (match && !mphase_q && hcnt_q != 16'hFFFF) hcnt_d = hcnt_q + 16'd1;
    if (match &&  mphase_q && vcnt_q != 16'hFFFF) vcnt_d = vcnt_q + 16'd1;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ROWS;
          along_d = '0;
          line_d  = '0;
          addr_d  = '0;
          horz_d  = '0;
          vert_d  = '0;
`ifdef FINDER_MATCH_COUNT_EN
          hcnt_d = '0;
          vcnt_d = '0;
`endif
        end
      end
      ROWS: begin
        addr_d = addr_q + ADDR_W'(1);
        if (along_q == LAST_X) begin
          along_d = '0;
          line_d  = line_q + COORD_W'(1);
          if (line_q == LAST_Y) begin
            state_d = COLS;
            line_d  = '0;
            addr_d  = '0;
          end
        end else begin
          along_d = along_q + COORD_W'(1);
        end
      end
      COLS: begin
        if (along_q == LAST_Y) begin
          along_d = '0;
          line_d  = line_q + COORD_W'(1);
          addr_d  = ADDR_W'(line_q) + ADDR_W'(1);
          if (line_q == LAST_X) begin
            state_d = DRAIN;
            addr_d  = '0;
            drain_d = '0;
          end
        end else begin
          along_d = along_q + COORD_W'(1);
          addr_d  = addr_q + STEP_Y;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State, address, tag pipeline and result registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      along_q  <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
      done_q   <= 1'b0;
      horz_q   <= '0;
      vert_q   <= '0;
      mphase_q <= 1'b0;
      tag_q    <= '0;
`ifdef FINDER_MATCH_COUNT_EN
      hcnt_q <= '0;
      vcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      along_q  <= along_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      horz_q   <= horz_d;
      vert_q   <= vert_d;
      mphase_q <= mphase_d;
      tag_q    <= tag_d;
`ifdef FINDER_MATCH_COUNT_EN
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
`endif
    end
  end

  assign address_out   = addr_q;
  assign horz_patterns = horz_q;
  assign vert_patterns = vert_q;
  assign done_out      = done_q;
  assign busy_out      = (state_q != IDLE) || done_q;
`ifdef FINDER_MATCH_COUNT_EN
  assign horz_match_count = hcnt_q;
  assign vert_match_count = vcnt_q;
`endif

endmodule

// File: tb/tb_finder_line_scanner.sv
// tb_finder_line_scanner: directed image vectors on a 16x16 image
// with a two-cycle BRAM model and hand-computed expected vectors.
module tb_finder_line_scanner;

  logic         clk = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic         pixel_in;
  logic [19:0]  address_out;
  logic [479:0] horz_patterns;
  logic [479:0] vert_patterns;
  logic         busy_out;
  logic         done_out;
`ifdef FINDER_MATCH_COUNT_EN
  logic [15:0]  hcnt;
  logic [15:0]  vcnt;
`endif

  logic img [0:255];
  logic d1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  finder_line_scanner #(
    .HEIGHT       (16),
    .WIDTH        (16),
    .READ_LATENCY (2)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .pixel_in      (pixel_in),
    .address_out   (address_out),
    .horz_patterns (horz_patterns),
    .vert_patterns (vert_patterns),
    .busy_out      (busy_out),
    .done_out      (done_out)
`ifdef FINDER_MATCH_COUNT_EN
    ,
    .horz_match_count (hcnt),
    .vert_match_count (vcnt)
`endif
  );

  // Two-stage BRAM read model
  always @(posedge clk) begin
    d1       <= (address_out < 20'd256) ? img[address_out[7:0]] : 1'b1;
    pixel_in <= d1;
  end

  task automatic check(input string tag, input logic [479:0] got,
                       input logic [479:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 1'b1;
  endtask

  task automatic blk(input int x, input int y, input int len);
    for (int i = 0; i < len; i++) img[y*16 + x + i] = 1'b0;
  endtask

  task automatic draw_finder();
    int dx, dy, d;
    for (int y = 4; y <= 10; y++) begin
      for (int x = 4; x <= 10; x++) begin
        dx = (x > 7) ? x - 7 : 7 - x;
        dy = (y > 7) ? y - 7 : 7 - y;
        d  = (dx > dy) ? dx : dy;
        if (d == 3 || d <= 1) img[y*16 + x] = 1'b0;
      end
    end
  endtask

  function automatic logic [479:0] bit_at(input int i);
    logic [479:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic scan(input bit probe);
    int cyc;
    int dcyc;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc  = 1;
    dcyc = 0;
    while (dcyc == 0 && cyc < 1200) begin
      if (probe) begin
        case (cyc)
          1: begin
            check("busy_c1", busy_out, 1);
            check("addr_c1", address_out, 0);
          end
          2:   check("addr_c2", address_out, 1);
          257: check("addr_c257", address_out, 0);
          258: check("addr_c258", address_out, 16);
          273: check("addr_c273", address_out, 1);
          512: check("addr_c512", address_out, 255);
          default: ;
        endcase
      end
      if (done_out) begin
        dcyc = cyc;
      end else begin
        start_in = probe && (cyc == 10);
        tick();
        cyc++;
      end
    end
    start_in = 1'b0;
    check("done_cycle", dcyc, 516);
    check("busy_at_done", busy_out, 1);
    tick();
    check("done_pulse", done_out, 0);
    check("busy_after", busy_out, 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst_in   = 1'b1;
    start_in = 1'b0;
    clear_img();
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    check("rst_addr", address_out, 0);
    check("rst_horz", horz_patterns, 0);
    check("rst_vert", vert_patterns, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);

    // All white, with ignored start at cycle 10
    scan(1'b1);
    check("white_horz", horz_patterns, 0);
    check("white_vert", vert_patterns, 0);

    // Row 5: B@3 W@4 B@5-7 W@8 B@9, centre 5+1
    clear_img();
    blk(3, 5, 1); blk(5, 5, 3); blk(9, 5, 1);
    scan(1'b0);
    check("row5_horz", horz_patterns, bit_at(6));
    check("row5_vert", vert_patterns, 0);

    // 7x7 finder at (4,4)..(10,10)
    clear_img();
    draw_finder();
    scan(1'b0);
    check("finder_horz", horz_patterns, bit_at(7));
    check("finder_vert", vert_patterns, bit_at(7));
`ifdef FINDER_MATCH_COUNT_EN
    check("finder_hcnt", hcnt, 3);
    check("finder_vcnt", vcnt, 3);
`endif

    // 2:2:6:2:2 from x=0: core starts at 4, length 6 -> 4+3
    clear_img();
    blk(0, 2, 2); blk(4, 2, 6); blk(12, 2, 2);
    scan(1'b0);
    check("r22622_horz", horz_patterns, bit_at(7));
    check("r22622_vert", vert_patterns, 0);

    // 1:1:5:1:1 from x=0: core 2..6 -> 2+2
    clear_img();
    blk(0, 2, 1); blk(2, 2, 5); blk(8, 2, 1);
    scan(1'b0);
    check("r11511_horz", horz_patterns, bit_at(4));
    check("r11511_vert", vert_patterns, 0);

    // 1:1:1:1:1 total too small
    clear_img();
    blk(0, 2, 1); blk(2, 2, 1); blk(4, 2, 1);
    scan(1'b0);
    check("r11111_horz", horz_patterns, 0);

    // Pattern closing at line end: core 11..13 -> 12
    clear_img();
    blk(9, 2, 1); blk(11, 2, 3); blk(15, 2, 1);
    scan(1'b0);
    check("lineend_horz", horz_patterns, bit_at(12));
    check("lineend_vert", vert_patterns, 0);

    // Same sequence split across rows 2 and 3
    clear_img();
    blk(12, 2, 1); blk(14, 2, 2); blk(0, 3, 1); blk(2, 3, 1);
    scan(1'b0);
    check("split_horz", horz_patterns, 0);
    check("split_vert", vert_patterns, 0);

    // Abort with reset in cycle 200, then a full rescan
    clear_img();
    draw_finder();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      tick();
      cyc++;
    end
    check("pre_abort_horz", horz_patterns, bit_at(7));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("abort_horz", horz_patterns, 0);
    check("abort_vert", vert_patterns, 0);
    check("abort_addr", address_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_done", done_out, 0);
    seen = 1'b0;
    repeat (600) begin
      if (done_out || busy_out) seen = 1'b1;
      tick();
    end
    check("abort_quiet", seen, 0);
    scan(1'b0);
    check("rescan_horz", horz_patterns, bit_at(7));
    check("rescan_vert", vert_patterns, bit_at(7));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
